// File: rtl/param_data_ram.sv
// Parametrised single-port data RAM with valid/ready requests, 1-cycle registered read response,
// out-of-range error flag, hardware zero sweep after reset or clear request, and debug probe taps.
module param_data_ram #(
  parameter int DATA_W    = 44,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int NUM_PROBE = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_req_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [DATA_W-1:0]           req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        busy_o,
  output logic [NUM_PROBE*DATA_W-1:0] probe_data_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                ready_q, busy_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range_s, accept_s, wr_s, rd_s;

  assign in_range_s = ({1'b0, req_addr_i} < DEPTH_EXT);
  assign accept_s   = req_valid_i & ready_q;
  assign wr_s       = accept_s & req_we_i & in_range_s;
  assign rd_s       = accept_s & ~req_we_i;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_req_i) begin
          state_d   = ST_INIT;
          clr_ptr_d = '0;
        end else begin
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // ready/busy are registered from the next state so they track state_q exactly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= (state_d == ST_RUN);
      busy_q    <= (state_d == ST_INIT);
    end
  end

  // No array writes in a reset cycle: the sweep restarts cleanly from word 0
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_s) begin
        mem_q[req_addr_i] <= req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_s;
      rsp_err_q   <= rd_s & ~in_range_s;
      if (rd_s) begin
        rsp_data_q <= in_range_s ? mem_q[req_addr_i] : '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_PROBE; k++) begin : g_probe
    assign probe_data_o[k*DATA_W +: DATA_W] = mem_q[k];
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_param_data_ram.sv
// Bench for param_data_ram: a 256-deep and a 200-deep instance share one stimulus stream and are
// each checked every cycle against an abstract model (word array plus remaining-clear-cycle count).
module tb_param_data_ram;
  localparam int DW = 44;
  localparam int AW = 8;
  localparam int NP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr_req, req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          ready_s [2];
  logic          rsp_valid_s [2];
  logic [DW-1:0] rsp_data_s [2];
  logic          rsp_err_s [2];
  logic          busy_s [2];
  logic [NP*DW-1:0] probe_s [2];

  param_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .NUM_PROBE(NP)) u_dut (
    .clk_i(clk), .rst_i(rst), .clr_req_i(clr_req), .req_valid_i(req_valid),
    .req_ready_o(ready_s[0]), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_s[0]), .rsp_data_o(rsp_data_s[0]), .rsp_err_o(rsp_err_s[0]),
    .busy_o(busy_s[0]), .probe_data_o(probe_s[0])
  );

  param_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .NUM_PROBE(NP)) u_dut200 (
    .clk_i(clk), .rst_i(rst), .clr_req_i(clr_req), .req_valid_i(req_valid),
    .req_ready_o(ready_s[1]), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_s[1]), .rsp_data_o(rsp_data_s[1]), .rsp_err_o(rsp_err_s[1]),
    .busy_o(busy_s[1]), .probe_data_o(probe_s[1])
  );

  // Reference model: word contents, cycles of clearing still to go, expected response registers
  int            depth [2] = '{256, 200};
  logic [DW-1:0] m_mem [2][256];
  int            init_left [2];
  logic          m_rv [2];
  logic          m_err [2];
  logic [DW-1:0] m_data [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        init_left[i] = depth[i];
        m_rv[i] = 1'b0; m_err[i] = 1'b0; m_data[i] = '0;
      end else if (init_left[i] > 0) begin
        m_mem[i][depth[i] - init_left[i]] = '0;
        init_left[i]--;
        m_rv[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        m_rv[i] = 1'b0; m_err[i] = 1'b0;
        if (req_valid) begin
          if (req_we) begin
            if (int'(req_addr) < depth[i]) m_mem[i][req_addr] = req_wdata;
          end else begin
            m_rv[i] = 1'b1;
            if (int'(req_addr) < depth[i]) m_data[i] = m_mem[i][req_addr];
            else begin m_data[i] = '0; m_err[i] = 1'b1; end
          end
        end
        if (clr_req) init_left[i] = depth[i];
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic bz;
      bz = (init_left[i] > 0);
      check($sformatf("busy[%0d]", i), 64'(busy_s[i]), 64'(bz));
      check($sformatf("ready[%0d]", i), 64'(ready_s[i]), 64'(!bz));
      check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid_s[i]), 64'(m_rv[i]));
      check($sformatf("rsp_err[%0d]", i), 64'(rsp_err_s[i]), 64'(m_err[i]));
      check($sformatf("rsp_data[%0d]", i), 64'(rsp_data_s[i]), 64'(m_data[i]));
      if (!bz) begin
        for (int k = 0; k < NP; k++)
          check($sformatf("probe[%0d][%0d]", i, k), 64'(probe_s[i][k*DW +: DW]), 64'(m_mem[i][k]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic clr, input logic r);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; clr_req = clr; rst = r;
    cycle();
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  // Count busy cycles of the 256-deep instance until it leaves INIT, with a bounded wait
  task automatic count_busy(input string tag, input int start_cnt, input logic hold_valid);
    int cnt;
    cnt = start_cnt;
    for (int n = 0; n < 400 && busy_s[0]; n++) begin
      drive(hold_valid, 1'b0, AW'($urandom_range(0, 255)), '0, 1'b0, 1'b0);
      if (busy_s[0]) cnt++;
    end
    check(tag, 64'(cnt), 64'd256);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      init_left[i] = 0; m_rv[i] = 1'b0; m_err[i] = 1'b0; m_data[i] = '0;
      for (int a = 0; a < 256; a++) m_mem[i][a] = '0;
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; clr_req = 1'b0; rst = 1'b1;

    // reset with a request held: no acceptance during the sweep
    drive(1'b1, 1'b0, 8'd0, '0, 1'b0, 1'b1);
    count_busy("t1_busy_cycles", 1, 1'b1);
    drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);

    // write then immediate read of the same word
    drive(1'b1, 1'b1, 8'd5, 44'h0AB_CDEF_0123, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd5, '0, 1'b0, 1'b0);
    check("t2_rsp_data", 64'(rsp_data_s[0]), 64'h0AB_CDEF_0123);
    drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);

    // out-of-range write and read on the 200-deep instance, then sweep all in-range words
    drive(1'b1, 1'b1, 8'd210, rand_word(), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd210, '0, 1'b0, 1'b0);
    check("t3_err", 64'(rsp_err_s[1]), 64'd1);
    for (int a = 0; a < 200; a++) drive(1'b1, 1'b0, AW'(a), '0, 1'b0, 1'b0);

    // back-to-back reads
    for (int a = 1; a <= 3; a++) drive(1'b1, 1'b1, AW'(a), rand_word(), 1'b0, 1'b0);
    for (int a = 1; a <= 3; a++) drive(1'b1, 1'b0, AW'(a), '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);

    // fill probe words, then clear with a read of word 3 in the same cycle
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b1, AW'(a), rand_word() | 44'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd3, '0, 1'b1, 1'b0);
    check("t5_old_word3", 64'(rsp_valid_s[0] && rsp_data_s[0] != '0), 64'd1);
    count_busy("t5_busy_cycles", 1, 1'b0);

    // reset in the middle of the sweep
    drive(1'b0, 1'b0, 8'd0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 99; n++) drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b1);
    count_busy("t6_busy_cycles", 1, 1'b0);

    // randomized traffic with occasional clears and resets
    for (int n = 0; n < 2000; n++) begin
      logic v, we, clr, r;
      v   = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 299) == 0);
      r   = ($urandom_range(0, 499) == 0);
      drive(v, we, AW'($urandom_range(0, 255)), rand_word(), clr, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
